motor_state_integrator: RTL

- Forward-Euler integrator stage that consumes di_dt/dw_dt from the motor derivative solver and produces the current (i) and speed (w) state vectors.
- The i/w outputs feed back into the derivative solver's i/w inputs, closing the simulation loop.
- Runs a commanded number of fixed time steps per start request and exposes busy/done status to the AXI wrapper.

---
 rtl/motor_state_integrator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/motor_state_integrator.sv
// Forward-Euler integrator for the motor current/speed state vectors.
// Runs num_steps fixed dt steps per start; i/w feed back to the derivative solver.
module motor_state_integrator #(
  parameter int DT_EXPONENT   = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int STEP_CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [STEP_CNT_W-1:0]        num_steps,
  input  logic [31:0]                  dt,
  input  logic signed [63:0]           i_init,
  input  logic signed [63:0]           w_init,
  input  logic signed [127:0]          di_dt,
  input  logic signed [127:0]          dw_dt,
  output logic signed [63:0]           i,
  output logic signed [63:0]           w,
  output logic                         busy,
  output logic                         done,
  output logic [STEP_CNT_W-1:0]        step_count,
  output logic                         sat_flag,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

  localparam logic [3:0]            SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [STEP_CNT_W-1:0] STEP_ONE    = STEP_CNT_W'(1);

  state_t                  state_q, state_d;
  logic [3:0]              settle_q, settle_d;
  logic [STEP_CNT_W-1:0]   steps_q;
  logic [31:0]             dt_q;
  logic [64:0]             i_step, w_step;
  logic                    accept, commit, last_step;

  // Returns {clamped, value}: x saturated to the signed 64-bit range.
  function automatic logic [64:0] clamp128(input logic [127:0] x);
    if (x[127:63] == {65{x[127]}})
      return {1'b0, x[63:0]};
    else
      return {1'b1, x[127] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF};
  endfunction

  // One Euler step: s + ((sat(d) * dt) >>> DT_EXPONENT), saturated; MSB flags any clamp.
  function automatic logic [64:0] euler(input logic [63:0] s, input logic [127:0] d,
                                        input logic [31:0] step_dt);
    logic [64:0]        dc;
    logic signed [96:0] p;
    logic signed [96:0] delta;
    logic [97:0]        sum;
    logic [64:0]        r;
    dc    = clamp128(d);
    p     = $signed(dc[63:0]) * $signed({1'b0, step_dt});
    delta = p >>> DT_EXPONENT;
    sum   = {{34{s[63]}}, s} + {delta[96], delta};
    if (sum[97:63] == {35{sum[97]}})
      r = {1'b0, sum[63:0]};
    else
      r = {1'b1, sum[97] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF};
    return {dc[64] | r[64], r[63:0]};
  endfunction

  assign i_step    = euler(i, di_dt, dt_q);
  assign w_step    = euler(w, dw_dt, dt_q);
  assign accept    = (state_q == IDLE) && start && !abort;
  assign commit    = (state_q == UPDATE) && !abort;
  assign last_step = (step_count + STEP_ONE) == steps_q;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EVAL;
          settle_d = SETTLE_INIT;
        end
      end
      EVAL: begin
        // The zero-step check uses the latched count, so an empty run still passes through here.
        if (abort)                     state_d = IDLE;
        else if (steps_q == '0)        state_d = DONE;
        else if (settle_q <= 4'd1)     state_d = UPDATE;
        else                           settle_d = settle_q - 4'd1;
      end
      UPDATE: begin
        if (abort)          state_d = IDLE;
        else if (last_step) state_d = DONE;
        else begin
          state_d  = EVAL;
          settle_d = SETTLE_INIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= 4'd0;
      steps_q    <= '0;
      dt_q       <= 32'd0;
      i          <= 64'sd0;
      w          <= 64'sd0;
      step_count <= '0;
      sat_flag   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      if (accept) begin
        steps_q    <= num_steps;
        dt_q       <= dt;
        i          <= i_init;
        w          <= w_init;
        step_count <= '0;
        sat_flag   <= 1'b0;
      end else if (commit) begin
        i          <= i_step[63:0];
        w          <= w_step[63:0];
        step_count <= step_count + STEP_ONE;
        sat_flag   <= sat_flag | i_step[64] | w_step[64];
      end
    end
  end

endmodule
